// File: rtl/mul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mul_seq
//  Description : Sequencer for the 8x16 multiply-accumulate datapath. Takes a
//                job of N operands, streams them in over valid/ready, keeps a
//                16-bit truncated running product with a sticky overflow
//                flag, and mirrors clock-enable/init strobes to the external
//                accumulator.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_seq #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic             abort,
    input  logic [7:0]       op_data,
    input  logic             op_valid,
    output logic             op_ready,
    output logic             busy,
    output logic             done,
    output logic [15:0]      result,
    output logic             ovf,
    output logic             ce_aku,
    output logic             init_aku
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      result_q, result_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic [23:0]      product;

    // Abort wins over acceptance, so an aborted cycle never consumes an operand.
    assign accept   = (state_q == S_RUN) && op_valid && !abort;
    assign product  = {8'd0, result_q} * {16'd0, op_data};

    assign op_ready = (state_q == S_RUN);
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign result   = result_q;
    assign ovf      = ovf_q;
    // Accumulator strobes are combinational so the shared datapath moves in
    // the same cycle as this sequencer.
    assign ce_aku   = accept;
    assign init_aku = (state_q == S_IDLE) && start;

    // Next-state and datapath update for the job sequencer.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    result_d = 16'h0001;
                    ovf_d    = 1'b0;
                    cnt_d    = count;
                    // An empty job is the empty product: finish immediately.
                    state_d  = (count == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (accept) begin
                    result_d = product[15:0];
                    ovf_d    = ovf_q | (product[23:16] != 8'd0);
                    cnt_d    = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; asynchronous reset drops any job in flight.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            result_q <= 16'h0001;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_seq
//  Description : Directed self-checking bench for mul_seq.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_seq;

    localparam int CNT_W = 4;

    logic             clk;
    logic             nReset;
    logic             start;
    logic [CNT_W-1:0] count;
    logic             abort;
    logic [7:0]       op_data;
    logic             op_valid;
    logic             op_ready;
    logic             busy;
    logic             done;
    logic [15:0]      result;
    logic             ovf;
    logic             ce_aku;
    logic             init_aku;

    int n_checks;
    int n_errors;

    mul_seq #(.CNT_W(CNT_W)) dut (
        .clk      (clk),
        .nReset   (nReset),
        .start    (start),
        .count    (count),
        .abort    (abort),
        .op_data  (op_data),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .ovf      (ovf),
        .ce_aku   (ce_aku),
        .init_aku (init_aku)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are then driven and
    // outputs sampled 1 time unit later, well away from any clock edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic [CNT_W-1:0] c, input logic a,
                         input logic v, input logic [7:0] d);
        start    = s;
        count    = c;
        abort    = a;
        op_valid = v;
        op_data  = d;
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        nReset   = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0, 8'd0);

        // ---------------- reset / idle ----------------
        #12;
        check("rst_result", {16'd0, result}, 32'h0001);
        check("rst_flags", {26'd0, op_ready, busy, done, ovf, ce_aku, init_aku}, 32'h0);
        nReset = 1'b1;
        next_cycle();
        next_cycle();
        check("idle_result", {16'd0, result}, 32'h0001);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // ---------------- job 2,3,4 -> 24 ----------------
        drive(1'b1, 4'd3, 1'b0, 1'b0, 8'd0);
        check("j1_c0_init", {31'd0, init_aku}, 32'd1);
        check("j1_c0_busy", {31'd0, busy}, 32'd0);
        next_cycle();
        drive(1'b0, 4'd0, 1'b0, 1'b1, 8'd2);
        check("j1_c1_rdy_ce_busy", {29'd0, op_ready, ce_aku, busy}, 32'b111);
        check("j1_c1_init", {31'd0, init_aku}, 32'd0);
        next_cycle();
        drive(1'b0, 4'd0, 1'b0, 1'b1, 8'd3);
        check("j1_c2_result", {16'd0, result}, 32'd2);
        check("j1_c2_ce", {31'd0, ce_aku}, 32'd1);
        next_cycle();
        drive(1'b0, 4'd0, 1'b0, 1'b1, 8'd4);
        check("j1_c3_result", {16'd0, result}, 32'd6);
        check("j1_c3_ce", {31'd0, ce_aku}, 32'd1);
        next_cycle();
        drive(1'b0, 4'd0, 1'b0, 1'b0, 8'd0);
        check("j1_c4_done", {30'd0, done, op_ready}, 32'b10);
        check("j1_c4_result", {16'd0, result}, 32'd24);
        check("j1_c4_ovf", {31'd0, ovf}, 32'd0);
        next_cycle();
        check("j1_c5_busy_done", {30'd0, busy, done}, 32'b00);

        // ---------------- job 200,200,2 -> 0x3880, ovf ----------------
        drive(1'b1, 4'd3, 1'b0, 1'b0, 8'd0);
        next_cycle();
        drive(1'b0, 4'd0, 1'b0, 1'b1, 8'd200);
        check("j2_c1_result_init", {16'd0, result}, 32'd1);
        next_cycle();
        drive(1'b0, 4'd0, 1'b0, 1'b1, 8'd200);
        next_cycle();
        drive(1'b0, 4'd0, 1'b0, 1'b1, 8'd2);
        check("j2_c3_result", {16'd0, result}, 32'h9C40);
        check("j2_c3_ovf", {31'd0, ovf}, 32'd0);
        next_cycle();
        drive(1'b0, 4'd0, 1'b0, 1'b0, 8'd0);
        check("j2_c4_done", {31'd0, done}, 32'd1);
        check("j2_c4_result", {16'd0, result}, 32'h3880);
        check("j2_c4_ovf", {31'd0, ovf}, 32'd1);
        next_cycle();
        next_cycle();
        check("j2_hold_result", {16'd0, result}, 32'h3880);
        check("j2_hold_ovf", {31'd0, ovf}, 32'd1);

        // ---------------- job 5,gap,gap,7 -> 35, start mid-job ignored ----------------
        drive(1'b1, 4'd2, 1'b0, 1'b0, 8'd0);
        next_cycle();
        drive(1'b0, 4'd0, 1'b0, 1'b1, 8'd5);
        check("j3_c1_ovf_cleared", {31'd0, ovf}, 32'd0);
        next_cycle();
        drive(1'b1, 4'd5, 1'b0, 1'b0, 8'd9);
        check("j3_c2_gap_ce_init", {30'd0, ce_aku, init_aku}, 32'b00);
        check("j3_c2_result", {16'd0, result}, 32'd5);
        next_cycle();
        drive(1'b0, 4'd0, 1'b0, 1'b0, 8'd0);
        check("j3_c3_gap_hold", {15'd0, done, result}, 32'd5);
        next_cycle();
        drive(1'b0, 4'd0, 1'b0, 1'b1, 8'd7);
        check("j3_c4_ce", {31'd0, ce_aku}, 32'd1);
        next_cycle();
        drive(1'b0, 4'd0, 1'b0, 1'b0, 8'd0);
        check("j3_c5_done", {31'd0, done}, 32'd1);
        check("j3_c5_result", {16'd0, result}, 32'd35);
        next_cycle();
        check("j3_c6_busy", {31'd0, busy}, 32'd0);

        // ---------------- empty job ----------------
        drive(1'b1, 4'd0, 1'b0, 1'b1, 8'd3);
        check("j4_c0_init_rdy", {30'd0, init_aku, op_ready}, 32'b10);
        next_cycle();
        drive(1'b0, 4'd0, 1'b0, 1'b1, 8'd3);
        check("j4_c1_done_rdy_ce", {29'd0, done, op_ready, ce_aku}, 32'b100);
        check("j4_c1_result_ovf", {15'd0, ovf, result}, 32'h0001);
        next_cycle();
        drive(1'b0, 4'd0, 1'b0, 1'b0, 8'd0);
        check("j4_c2_idle", {29'd0, busy, done, op_ready}, 32'b000);

        // ---------------- abort after 3,3 ----------------
        drive(1'b1, 4'd4, 1'b0, 1'b0, 8'd0);
        next_cycle();
        drive(1'b0, 4'd0, 1'b0, 1'b1, 8'd3);
        next_cycle();
        drive(1'b0, 4'd0, 1'b0, 1'b1, 8'd3);
        next_cycle();
        drive(1'b0, 4'd0, 1'b1, 1'b1, 8'd3);
        check("j5_abort_ce", {31'd0, ce_aku}, 32'd0);
        check("j5_abort_result", {16'd0, result}, 32'd9);
        next_cycle();
        check("j5_after_busy_done", {30'd0, busy, done}, 32'b00);
        check("j5_after_result", {16'd0, result}, 32'd9);
        next_cycle();
        drive(1'b0, 4'd0, 1'b0, 1'b0, 8'd0);
        check("j5_later", {14'd0, busy, done, result}, 32'd9);

        // ---------------- async reset mid-run ----------------
        drive(1'b1, 4'd3, 1'b0, 1'b0, 8'd0);
        next_cycle();
        drive(1'b0, 4'd0, 1'b0, 1'b1, 8'd5);
        next_cycle();
        drive(1'b0, 4'd0, 1'b0, 1'b1, 8'd6);
        check("j6_pre_rst_result", {16'd0, result}, 32'd5);
        #2;
        nReset = 1'b0;
        #1;
        check("j6_rst_flags", {26'd0, op_ready, busy, done, ovf, ce_aku, init_aku}, 32'h0);
        check("j6_rst_result", {16'd0, result}, 32'h0001);
        drive(1'b0, 4'd0, 1'b0, 1'b0, 8'd0);
        next_cycle();
        #2;
        nReset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            check("j6_no_done", {30'd0, busy, done}, 32'b00);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
